out_bus_arbiter: RTL and testbench

//  Shares the single 8-bit out_bus between the PC, MAR and MDR shift paths.

---
 rtl/out_bus_arbiter_pkg.sv | 27 ++
 rtl/out_bus_arbiter_rr_picker.sv | 49 ++++
 rtl/out_bus_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_out_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// out_bus_arbiter_pkg
//   Shared types and constants for the out_bus arbiter and its round-robin
//   picker.
//   - arb_state_t : arbiter FSM states
//   - REQ_*       : requester indices on the shared out_bus
//   - wrap_inc    : modulo-n increment used to advance round-robin pointers
// ----------------------------------------------------------------------------
package out_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_HI = 3'd1,
        SEND_LO = 3'd2,
        DONE    = 3'd3,
        ABORT   = 3'd4
    } arb_state_t;

    localparam int REQ_PC  = 0;
    localparam int REQ_MAR = 1;
    localparam int REQ_MDR = 2;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/out_bus_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// out_bus_arbiter_rr_picker
//   Combinational round-robin picker: selects the first set request at or
//   after ptr, wrapping around. Written generically so other bus sharers can
//   reuse it.
//   Ports:
//     req        in   N      request vector
//     ptr        in   IDX_W  index with highest priority this round (< N)
//     grant_next out  N      one-hot winner, 0 when no request
//     grant_idx  out  IDX_W  index of the winner, 0 when no request
//     any_req    out  1      at least one request is set
// ----------------------------------------------------------------------------
module out_bus_arbiter_rr_picker #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_next,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_req
);

    int               idx;
    logic [IDX_W-1:0] sel;

    always_comb begin
        grant_next = '0;
        grant_idx  = '0;
        any_req    = |req;
        idx        = 0;
        sel        = '0;
        // Scan from the farthest offset down to ptr itself so the last
        // hit written is the closest one to ptr in wrap order.
        for (int off = N - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = IDX_W'(idx);
            if (req[sel]) begin
                grant_next      = '0;
                grant_next[sel] = 1'b1;
                grant_idx       = sel;
            end
        end
    end

endmodule

// File: rtl/out_bus_arbiter.sv
// ----------------------------------------------------------------------------
// out_bus_arbiter
//   Shares the 8-bit out_bus between the PC, MAR and MDR shift paths. A
//   round-robin winner's 16-bit word is latched and sent high byte first,
//   each byte moved with a valid/ready handshake.
//
//   Handshake: a byte is transferred at a rising clk edge where
//   data_out_ready==1 and ard_receive_ready==1. While data_out_ready is high
//   out_bus is held stable until that edge.
//
//   Ports:
//     clk, rst          clock (rising edge), asynchronous active-high reset
//     req               per-requester request, held until done
//     word_in           flattened words, requester i at [i*WORD_W +: WORD_W]
//     ard_receive_ready receiver accepts the offered byte this cycle
//     grant             one-hot bus owner (held through DONE), 0 when idle
//     done              one-cycle pulse for the requester whose word finished
//     out_bus           byte offered to the receiver
//     data_out_ready    out_bus holds a valid byte
//     shift_done        one-cycle pulse on any completed word
//     busy              FSM not in IDLE
//     timeout_err       sticky: a byte waited too long; cleared only by rst
// ----------------------------------------------------------------------------
module out_bus_arbiter
    import out_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int WORD_W  = 16,
    parameter int BYTE_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*WORD_W-1:0] word_in,
    input  logic                      ard_receive_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [BYTE_W-1:0]         out_bus,
    output logic                      data_out_ready,
    output logic                      shift_done,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t          state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                shift_done_q, shift_done_d;
    logic                data_out_ready_q, data_out_ready_d;
    logic                busy_q, busy_d;
    logic                timeout_err_q, timeout_err_d;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [WORD_W-1:0]   pick_word;
    logic                sending;
    logic                accept;
    logic                timeout_hit;
    logic [IDX_W-1:0]    next_ptr;

    out_bus_arbiter_rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req        (req),
        .ptr        (ptr_q),
        .grant_next (pick_onehot),
        .grant_idx  (pick_idx),
        .any_req    (pick_any)
    );

    always_comb begin
        pick_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                pick_word = word_in[i*WORD_W +: WORD_W];
            end
        end
    end

    assign sending     = (state_q == SEND_HI) || (state_q == SEND_LO);
    assign accept      = sending && ard_receive_ready;
    // A missing accept on the last allowed cycle aborts; TIMEOUT==0 never does.
    assign timeout_hit = (TIMEOUT != 0) && sending && !accept && (cnt_q == CNT_LAST);
    assign next_ptr    = IDX_W'(wrap_inc(int'(idx_q), NUM_REQ));

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        // Counter restarts at 0 on every entry into a SEND state.
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = SEND_HI;
                    word_d  = pick_word;
                    idx_d   = pick_idx;
                    grant_d = pick_onehot;
                end
            end
            SEND_HI, SEND_LO: begin
                if (accept) begin
                    state_d = (state_q == SEND_HI) ? SEND_LO : DONE;
                end else if (timeout_hit) begin
                    state_d = ABORT;
                    grant_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = next_ptr;
            end
            ABORT: begin
                state_d = IDLE;
                ptr_d   = next_ptr;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        // Flag outputs are registered from the next state so they line up
        // with the state they describe.
        done_d           = (state_d == DONE) ? grant_q : '0;
        shift_done_d     = (state_d == DONE);
        data_out_ready_d = (state_d == SEND_HI) || (state_d == SEND_LO);
        busy_d           = (state_d != IDLE);
        timeout_err_d    = timeout_err_q || (state_d == ABORT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            word_q           <= '0;
            idx_q            <= '0;
            ptr_q            <= '0;
            cnt_q            <= '0;
            grant_q          <= '0;
            done_q           <= '0;
            shift_done_q     <= 1'b0;
            data_out_ready_q <= 1'b0;
            busy_q           <= 1'b0;
            timeout_err_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            word_q           <= word_d;
            idx_q            <= idx_d;
            ptr_q            <= ptr_d;
            cnt_q            <= cnt_d;
            grant_q          <= grant_d;
            done_q           <= done_d;
            shift_done_q     <= shift_done_d;
            data_out_ready_q <= data_out_ready_d;
            busy_q           <= busy_d;
            timeout_err_q    <= timeout_err_d;
        end
    end

    always_comb begin
        case (state_q)
            SEND_HI: out_bus = word_q[WORD_W-1:BYTE_W];
            SEND_LO: out_bus = word_q[BYTE_W-1:0];
            default: out_bus = '0;
        endcase
    end

    assign grant          = grant_q;
    assign done           = done_q;
    assign shift_done     = shift_done_q;
    assign data_out_ready = data_out_ready_q;
    assign busy           = busy_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_out_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_out_bus_arbiter
//   Directed bench for out_bus_arbiter. Inputs change on the falling edge and
//   outputs are sampled on the falling edge. Each sample packs the outputs as
//   {grant, done, out_bus, data_out_ready, shift_done, busy, timeout_err}.
//   dut uses the default TIMEOUT; dut_to uses TIMEOUT=4 with its own req and
//   ready inputs so the abort path can be exercised on a short budget.
// ----------------------------------------------------------------------------
module tb_out_bus_arbiter;
    import out_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  req_t = '0;
    logic [47:0] word_in = '0;
    logic        ready = 1'b0;
    logic        ready_t = 1'b0;

    logic [2:0]  grant, done, t_grant, t_done;
    logic [7:0]  out_bus, t_out_bus;
    logic        dor, sd, busy, err, t_dor, t_sd, t_busy, t_err;

    logic [17:0] obs, tobs, exp;
    int          cmp_count = 0;
    int          fail_count = 0;

    assign obs  = {grant, done, out_bus, dor, sd, busy, err};
    assign tobs = {t_grant, t_done, t_out_bus, t_dor, t_sd, t_busy, t_err};

    out_bus_arbiter dut (
        .clk (clk), .rst (rst), .req (req), .word_in (word_in),
        .ard_receive_ready (ready), .grant (grant), .done (done),
        .out_bus (out_bus), .data_out_ready (dor), .shift_done (sd),
        .busy (busy), .timeout_err (err)
    );

    out_bus_arbiter #(.TIMEOUT(4)) dut_to (
        .clk (clk), .rst (rst), .req (req_t), .word_in (word_in),
        .ard_receive_ready (ready_t), .grant (t_grant), .done (t_done),
        .out_bus (t_out_bus), .data_out_ready (t_dor), .shift_done (t_sd),
        .busy (t_busy), .timeout_err (t_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0; req_t = '0; ready = 1'b0; ready_t = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        exp = '0;
        cmp_count++;
        if (obs !== exp) begin fail_count++; $display("FAIL reset_main: got %h exp %h", obs, exp); end
        cmp_count++;
        if (tobs !== exp) begin fail_count++; $display("FAIL reset_to: got %h exp %h", tobs, exp); end
    endtask

    task automatic test_single();
        apply_reset();
        word_in[REQ_PC*16 +: 16] = 16'hA55A;
        ready = 1'b1;
        req = 3'b001;
        @(negedge clk);
        exp = {3'b001, 3'b000, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0};
        cmp_count++;
        if (obs !== exp) begin fail_count++; $display("FAIL single_hi: got %h exp %h", obs, exp); end
        @(negedge clk);
        exp = {3'b001, 3'b000, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0};
        cmp_count++;
        if (obs !== exp) begin fail_count++; $display("FAIL single_lo: got %h exp %h", obs, exp); end
        @(negedge clk);
        exp = {3'b001, 3'b001, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        cmp_count++;
        if (obs !== exp) begin fail_count++; $display("FAIL single_done: got %h exp %h", obs, exp); end
        req = 3'b000;
        @(negedge clk);
        exp = '0;
        cmp_count++;
        if (obs !== exp) begin fail_count++; $display("FAIL single_idle: got %h exp %h", obs, exp); end
    endtask

    task automatic test_round_robin();
        logic [15:0] w;
        logic [2:0]  g;
        apply_reset();
        word_in = {16'h3333, 16'h2222, 16'h1111};
        ready = 1'b1;
        req = 3'b111;
        for (int k = 0; k < 3; k++) begin
            g = 3'b001 << k;
            w = (k == 0) ? 16'h1111 : (k == 1) ? 16'h2222 : 16'h3333;
            @(negedge clk);
            exp = {g, 3'b000, w[15:8], 1'b1, 1'b0, 1'b1, 1'b0};
            cmp_count++;
            if (obs !== exp) begin fail_count++; $display("FAIL rr_hi[%0d]: got %h exp %h", k, obs, exp); end
            @(negedge clk);
            exp = {g, 3'b000, w[7:0], 1'b1, 1'b0, 1'b1, 1'b0};
            cmp_count++;
            if (obs !== exp) begin fail_count++; $display("FAIL rr_lo[%0d]: got %h exp %h", k, obs, exp); end
            @(negedge clk);
            exp = {g, g, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
            cmp_count++;
            if (obs !== exp) begin fail_count++; $display("FAIL rr_done[%0d]: got %h exp %h", k, obs, exp); end
            req[k] = 1'b0;
            @(negedge clk);
            exp = '0;
            cmp_count++;
            if (obs !== exp) begin fail_count++; $display("FAIL rr_idle[%0d]: got %h exp %h", k, obs, exp); end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        word_in[REQ_MAR*16 +: 16] = 16'hBEEF;
        ready = 1'b0;
        req = 3'b010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp = {3'b010, 3'b000, 8'hBE, 1'b1, 1'b0, 1'b1, 1'b0};
            cmp_count++;
            if (obs !== exp) begin fail_count++; $display("FAIL bp_hold[%0d]: got %h exp %h", i, obs, exp); end
        end
        ready = 1'b1;
        @(negedge clk);
        exp = {3'b010, 3'b000, 8'hEF, 1'b1, 1'b0, 1'b1, 1'b0};
        cmp_count++;
        if (obs !== exp) begin fail_count++; $display("FAIL bp_lo: got %h exp %h", obs, exp); end
        @(negedge clk);
        exp = {3'b010, 3'b010, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        cmp_count++;
        if (obs !== exp) begin fail_count++; $display("FAIL bp_done: got %h exp %h", obs, exp); end
        req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        apply_reset();
        word_in[REQ_PC*16 +: 16]  = 16'hC3D2;
        word_in[REQ_MAR*16 +: 16] = 16'h7E81;
        ready_t = 1'b0;
        req_t = 3'b001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp = {3'b001, 3'b000, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b0};
            cmp_count++;
            if (tobs !== exp) begin fail_count++; $display("FAIL to_wait[%0d]: got %h exp %h", i, tobs, exp); end
        end
        @(negedge clk);
        exp = {3'b000, 3'b000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
        cmp_count++;
        if (tobs !== exp) begin fail_count++; $display("FAIL to_abort: got %h exp %h", tobs, exp); end
        req_t = 3'b011;
        ready_t = 1'b1;
        @(negedge clk);
        exp = {3'b000, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        cmp_count++;
        if (tobs !== exp) begin fail_count++; $display("FAIL to_idle: got %h exp %h", tobs, exp); end
        @(negedge clk);
        exp = {3'b010, 3'b000, 8'h7E, 1'b1, 1'b0, 1'b1, 1'b1};
        cmp_count++;
        if (tobs !== exp) begin fail_count++; $display("FAIL to_next_hi: got %h exp %h", tobs, exp); end
        @(negedge clk);
        exp = {3'b010, 3'b000, 8'h81, 1'b1, 1'b0, 1'b1, 1'b1};
        cmp_count++;
        if (tobs !== exp) begin fail_count++; $display("FAIL to_next_lo: got %h exp %h", tobs, exp); end
        @(negedge clk);
        exp = {3'b010, 3'b010, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
        cmp_count++;
        if (tobs !== exp) begin fail_count++; $display("FAIL to_next_done: got %h exp %h", tobs, exp); end
        req_t = 3'b000;
        exp = '0;
        cmp_count++;
        if (obs !== exp) begin fail_count++; $display("FAIL to_main_quiet: got %h exp %h", obs, exp); end
        @(negedge clk);
    endtask

    task automatic test_word_change();
        apply_reset();
        word_in[REQ_MDR*16 +: 16] = 16'h1234;
        ready = 1'b1;
        req = 3'b100;
        @(negedge clk);
        exp = {3'b100, 3'b000, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0};
        cmp_count++;
        if (obs !== exp) begin fail_count++; $display("FAIL wc_hi: got %h exp %h", obs, exp); end
        word_in[REQ_MDR*16 +: 16] = 16'hFFFF;
        @(negedge clk);
        exp = {3'b100, 3'b000, 8'h34, 1'b1, 1'b0, 1'b1, 1'b0};
        cmp_count++;
        if (obs !== exp) begin fail_count++; $display("FAIL wc_lo: got %h exp %h", obs, exp); end
        @(negedge clk);
        exp = {3'b100, 3'b100, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        cmp_count++;
        if (obs !== exp) begin fail_count++; $display("FAIL wc_done: got %h exp %h", obs, exp); end
        req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        word_in[REQ_PC*16 +: 16]  = 16'h6996;
        word_in[REQ_MAR*16 +: 16] = 16'h5AA5;
        ready = 1'b1;
        req = 3'b010;
        @(negedge clk);
        exp = {3'b010, 3'b000, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0};
        cmp_count++;
        if (obs !== exp) begin fail_count++; $display("FAIL rm_hi: got %h exp %h", obs, exp); end
        @(negedge clk);
        exp = {3'b010, 3'b000, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0};
        cmp_count++;
        if (obs !== exp) begin fail_count++; $display("FAIL rm_lo: got %h exp %h", obs, exp); end
        #2 rst = 1'b1;
        #1;
        exp = '0;
        cmp_count++;
        if (obs !== exp) begin fail_count++; $display("FAIL rm_async: got %h exp %h", obs, exp); end
        req = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp = '0;
        cmp_count++;
        if (obs !== exp) begin fail_count++; $display("FAIL rm_no_done: got %h exp %h", obs, exp); end
        req = 3'b011;
        @(negedge clk);
        exp = {3'b001, 3'b000, 8'h69, 1'b1, 1'b0, 1'b1, 1'b0};
        cmp_count++;
        if (obs !== exp) begin fail_count++; $display("FAIL rm_ptr0: got %h exp %h", obs, exp); end
        @(negedge clk);
        @(negedge clk);
        exp = {3'b001, 3'b001, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        cmp_count++;
        if (obs !== exp) begin fail_count++; $display("FAIL rm_after_done: got %h exp %h", obs, exp); end
        req = 3'b000;
        @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_word_change();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
